// File: rtl/rr_sel_pkg.sv
// rr_sel_pkg
// Shared types and constants for the 3-way round-robin select arbiter.
//   state_t     : arbiter state (idle / grant held)
//   SEL_*       : one-hot select encodings for the downstream 3:1 mux
//   sel_to_idx  : converts a one-hot select into a 2-bit source index
package rr_sel_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_0    = 3'b001;
  localparam logic [2:0] SEL_1    = 3'b010;
  localparam logic [2:0] SEL_2    = 3'b100;

  // Zero or an illegal pattern maps to index 0. The arbiter only calls this
  // with a non-zero pick, so that case is never stored.
  function automatic logic [1:0] sel_to_idx(input logic [2:0] sel);
    logic [1:0] idx;
    idx = 2'd0;
    case (sel)
      SEL_1:   idx = 2'd1;
      SEL_2:   idx = 2'd2;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick_3.sv
// rr_pick_3
// Purely combinational round-robin pick for three requesters.
// Scans the sources starting just after the most recent grantee, so the
// previous grantee always has the lowest priority.
//   req  [2:0] in  : request lines
//   last [1:0] in  : index of the most recent grantee (0..2)
//   pick [2:0] out : one-hot winner, 3'b000 when no request is set
module rr_pick_3
  import rr_sel_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [2:0] pick
);

  // Each value of last fixes a rotated priority order. An out-of-range value
  // (3) is treated like last=2, so source 0 gets first priority.
  always_comb begin
    pick = SEL_NONE;
    case (last)
      2'd0: begin
        if (req[1])      pick = SEL_1;
        else if (req[2]) pick = SEL_2;
        else if (req[0]) pick = SEL_0;
      end
      2'd1: begin
        if (req[2])      pick = SEL_2;
        else if (req[0]) pick = SEL_0;
        else if (req[1]) pick = SEL_1;
      end
      default: begin
        if (req[0])      pick = SEL_0;
        else if (req[1]) pick = SEL_1;
        else if (req[2]) pick = SEL_2;
      end
    endcase
  end

endmodule

// File: rtl/rr_sel_3.sv
// rr_sel_3
// Round-robin arbiter for three sources. It produces a registered,
// glitch-free one-hot select for a downstream 3:1 mux. A grant may be held
// for up to BURST accepted beats before re-arbitration.
//   clk        in  : clock, rising edge
//   rst_n      in  : asynchronous active-low reset
//   req  [2:0] in  : per-source requests, held until acked
//   out_ready  in  : downstream accepts the mux output this cycle
//   s    [2:0] out : registered one-hot select, 000 when idle
//   s_valid    out : s holds a valid grant
//   ack  [2:0] out : per-source accept strobe (combinational on out_ready)
module rr_sel_3
  import rr_sel_pkg::*;
#(
  parameter int BURST = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic       out_ready,
  output logic [2:0] s,
  output logic       s_valid,
  output logic [2:0] ack
);

  localparam int              CW      = $clog2(BURST) + 1;
  localparam logic [CW-1:0]   BURST_C = CW'(BURST);
  localparam logic [CW-1:0]   ONE_C   = CW'(1);

  state_t          state_q, state_d;
  logic [2:0]      s_q, s_d;
  logic [1:0]      last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   cnt_inc;
  logic [2:0]      pick;
  logic            req_held;

  rr_pick_3 u_pick (
    .req  (req),
    .last (last_q),
    .pick (pick)
  );

  // In GRANT, s_q is the one-hot form of last_q. Masking req with s_q
  // therefore gives req[last] without a variable index.
  assign req_held = |(req & s_q);
  assign cnt_inc  = cnt_q + ONE_C;

  // Next-state logic. Everything holds by default. A handshake either extends
  // the burst or re-arbitrates in the same edge, so grants run back-to-back
  // with no idle bubble.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_GRANT;
          s_d     = pick;
          last_d  = sel_to_idx(pick);
          cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        if (out_ready) begin
          if (req_held && (cnt_inc < BURST_C)) begin
            cnt_d = cnt_inc;
          end else if (pick != SEL_NONE) begin
            s_d    = pick;
            last_d = sel_to_idx(pick);
            cnt_d  = '0;
          end else begin
            state_d = ST_IDLE;
            s_d     = SEL_NONE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        s_d     = SEL_NONE;
        cnt_d   = '0;
      end
    endcase
  end

  // After reset, last points at source 2, so source 0 wins the first arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      s_q     <= SEL_NONE;
      last_q  <= 2'd2;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign s       = s_q;
  assign s_valid = (state_q == ST_GRANT);
  assign ack     = s_q & {3{s_valid & out_ready}};

endmodule

// File: doc/rr_sel_3.md
# rr_sel_3

Three-requester round-robin arbiter that generates the registered one-hot select `s[2:0]` for the downstream 3:1 one-hot data multiplexer (`3'b001`→a0, `3'b010`→a1, `3'b100`→a2). It sits directly upstream of that mux. It turns per-source request lines and a downstream ready into a stable, glitch-free one-hot select plus a qualifying valid. It supports optional burst hold, so one source can keep the grant for up to `BURST` consecutive transfers.

## Interface
Parameters:
- `BURST`, 1: max consecutive accepted transfers per grant; legal range 1..16.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  3  per-source request; bit i = source i has a beat pending; must stay high until `ack[i]`.
- `out_ready`  in  1  downstream consumer accepts the mux output this cycle.
- `s`  out  3  registered one-hot select to the mux; `3'b000` when idle.
- `s_valid`  out  1  `s` is a valid grant; mux output is meaningful only when high.
- `ack`  out  3  combinational; `ack = s & {3{s_valid & out_ready}}`; one-hot or zero.

## Operation
- States: IDLE (no grant, `s=000`, `s_valid=0`) and GRANT (`s` one-hot, `s_valid=1`).
- Registered state: state, `s`, `last` (2-bit index of most recent grantee), and `cnt` (beats accepted in current grant, width `$clog2(BURST)+1`).
- Pick function, with `req` and `last` as inputs: scan indices `last+1`, `last+2`, `last+3` (mod 3) and return the first with `req` set as one-hot. Return `000` if none is set.
- IDLE:
  - If `|req`, load `s` = pick, set `last` = its index, `cnt` = 0, and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT without handshake (`out_ready=0`): hold `s`, `cnt`, and `last` unchanged. The grant is sticky even if the granted `req` drops, which is a protocol violation and is not checked.
- GRANT with handshake (`out_ready=1`): `cnt_next = cnt+1`.
  - Keep the grant if `req[last]` is still high and `cnt_next < BURST`: `s` unchanged, `cnt = cnt_next`.
  - Otherwise re-arbitrate in the same edge:
    - If pick is non-zero, load `s` = pick, set `last` to its index, and set `cnt` = 0. The current grantee has the lowest priority.
    - If pick is zero, go to IDLE with `s=000`.
- With `BURST=1`, every handshake re-arbitrates. This gives strict round-robin.
- `s` is never anything other than `000`, `001`, `010` or `100`.
- The `req` value used on a handshake cycle includes the grantee's own bit. This lets a sole active source keep being re-granted back-to-back.

## Timing
- Reset (async assert, sync-style release on next edge):
  - `s=000`, `s_valid=0`, state=IDLE, `cnt=0`.
  - `last=2`, so source 0 has first priority after reset.
  - `ack=000`.
- Latency from `req` rising in IDLE to `s`/`s_valid`: 1 cycle.
- Back-to-back throughput: one beat per cycle while requests persist, with no idle bubble between grants.
- `ack` depends combinationally on `out_ready`. `s` and `s_valid` are registered only, with no combinational path from `req` or `out_ready`.
- Reset asserted mid-grant: outputs drop to reset values immediately. There is no completion of the in-flight beat.
- Simultaneous requests on all three sources with `BURST=1`: grants follow the order 0, 1, 2, 0, …

## Structure
- Package `rr_sel_pkg`:
  - state enum `{ST_IDLE, ST_GRANT}`.
  - select constants `SEL_NONE=3'b000`, `SEL_0=3'b001`, `SEL_1=3'b010`, `SEL_2=3'b100`.
  - function converting a one-hot select to a 2-bit index.
- Sub-module `rr_pick_3`: purely combinational. Inputs are `req[2:0]` and `last[1:0]`; output is a one-hot pick. It is instantiated once and is reusable by other arbiters.
- Top-level `rr_sel_3`: state/counter registers and `ack` logic. Target size is 120–250 lines total.

## Test plan
- Reset with `req=111` held: `s=000` and `s_valid=0` during reset. One cycle after release, `s=001`.
- `BURST=1`, `req=111`, `out_ready=1` for 6 cycles: `s` sequence is `001,010,100,001,010,100`. `ack` equals `s` each cycle.
- `req=010` only, `out_ready` toggling 1,0,1: `s=010` throughout. `ack=010` only on ready cycles. `s_valid` never drops.
- `BURST=4`, `req=101`, `out_ready=1`: `s=001` for 4 beats, then `100` for 4 beats, then `001`.
- Grant on source 2, `out_ready=0` for 5 cycles while `req` changes to `011`: `s` holds `100`. On ready, the next `s` is `001`.
- Assert `rst_n=0` mid-burst with `s=010`: `s=000` and `s_valid=0` in the same cycle, asynchronously.
